pipe_seg_hs: RTL and testbench

//   Generic parametrised pipeline segment register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_seg_hs.sv | 141 ++++++++++++++
 tb/tb_pipe_seg_hs.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_seg_hs.sv
// pipe_seg_hs: generic pipeline segment register with a valid/ready handshake.
// It carries one opaque payload bus and supports flush. With SKID=1 it adds a
// 2-entry skid buffer, so in_ready comes straight from a flop and the backward
// stall path is cut. With SKID=0 it is a single entry whose in_ready passes
// out_ready through combinationally.
module pipe_seg_hs #(
    parameter int              DW     = 160,
    parameter int              SKID   = 1,
    parameter logic [DW-1:0]   RSTVAL = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    occ
);

    logic          accept;
    logic          pop;
    logic [DW-1:0] m_q;     // main register, always the oldest entry

    assign accept   = in_valid & in_ready;
    assign pop      = out_valid & out_ready;
    assign out_data = m_q;

    if (SKID != 0) begin : g_skid
        typedef enum logic [1:0] {
            EMPTY = 2'd0,
            ONE   = 2'd1,
            TWO   = 2'd2
        } state_t;

        state_t        state_q, state_d;
        logic          rdy_q;
        logic [DW-1:0] s_q;     // skid register, younger entry when TWO
        logic          load_m_in, load_m_s, load_s;

        // Next-state and payload-load decode. Flush overrides everything and
        // also suppresses the load of a same-cycle accept.
        always_comb begin
            // NOTE: every output gets a default first so no path leaves a
            // variable unassigned, which would infer a latch.
            state_d   = state_q;
            load_m_in = 1'b0;
            load_m_s  = 1'b0;
            load_s    = 1'b0;
            if (flush) begin
                state_d = EMPTY;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (accept) begin
                            load_m_in = 1'b1;
                            state_d   = ONE;
                        end
                    end
                    ONE: begin
                        if (accept && pop) begin
                            load_m_in = 1'b1;
                        end else if (accept) begin
                            load_s  = 1'b1;
                            state_d = TWO;
                        end else if (pop) begin
                            state_d = EMPTY;
                        end
                    end
                    TWO: begin
                        if (pop) begin
                            load_m_s = 1'b1;
                            state_d  = ONE;
                        end
                    end
                    default: state_d = EMPTY;
                endcase
            end
        end

        // State register plus a registered copy of "not full" for in_ready.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                // NOTE: sequential state uses non-blocking assignments so all
                // flops sample the pre-edge values regardless of block order.
                state_q <= EMPTY;
                rdy_q   <= 1'b1;
            end else begin
                state_q <= state_d;
                rdy_q   <= (state_d != TWO);
            end
        end

        // Payload registers load only on accept or on the TWO->ONE shift.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                // NOTE: payload registers are reset deliberately so out_data
                // shows a known value after reset.
                m_q <= RSTVAL;
                s_q <= RSTVAL;
            end else begin
                if (load_m_in) begin
                    m_q <= in_data;
                end else if (load_m_s) begin
                    m_q <= s_q;
                end
                if (load_s) begin
                    s_q <= in_data;
                end
            end
        end

        assign in_ready  = rdy_q;
        assign out_valid = (state_q != EMPTY);
        assign occ       = state_q;
    end else begin : g_single
        logic v_q;

        // Single entry: accept refills M (even while popping), pop alone empties it.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                v_q <= 1'b0;
                m_q <= RSTVAL;
            end else if (flush) begin
                v_q <= 1'b0;
            end else if (accept) begin
                v_q <= 1'b1;
                m_q <= in_data;
            end else if (pop) begin
                v_q <= 1'b0;
            end
        end

        assign in_ready  = ~v_q | out_ready;
        assign out_valid = v_q;
        assign occ       = {1'b0, v_q};
    end

endmodule

// File: tb/tb_pipe_seg_hs.sv
// Bench for pipe_seg_hs: directed checks on a SKID=1 and a SKID=0 instance,
// then random traffic on four instances (both SKID values, DW=160 and DW=1)
// against a depth-limited reference FIFO.
module tb_pipe_seg_hs;

    localparam logic [159:0] RV_A = 160'hDEAD_BEEF_0000_1234;
    localparam logic [159:0] VAL_A = 160'hAAAA_0001;
    localparam logic [159:0] VAL_B = 160'hBBBB_0002;
    localparam logic [159:0] VAL_C = 160'hCCCC_0003;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         out_ready;
    logic [159:0] in_data;

    logic         a_rdy, a_ov, b_rdy, b_ov, c_rdy, c_ov, d_rdy, d_ov;
    logic [1:0]   a_occ, b_occ, c_occ, d_occ;
    logic [159:0] a_od, b_od;
    logic [0:0]   c_od, d_od;

    int total = 0;
    int bad   = 0;

    int           cnt  [4];
    logic [159:0] e0   [4];
    logic [159:0] e1   [4];
    bit           skid [4];
    logic [159:0] mask [4];

    always #5 clk = ~clk;

    pipe_seg_hs #(.DW(160), .SKID(1), .RSTVAL(RV_A)) u_a (
        .clk(clk), .reset(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_rdy),
        .in_data(in_data), .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od), .occ(a_occ));
    pipe_seg_hs #(.DW(160), .SKID(0), .RSTVAL(RV_A)) u_b (
        .clk(clk), .reset(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_rdy),
        .in_data(in_data), .out_valid(b_ov), .out_ready(out_ready), .out_data(b_od), .occ(b_occ));
    pipe_seg_hs #(.DW(1), .SKID(1), .RSTVAL(1'b1)) u_c (
        .clk(clk), .reset(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_rdy),
        .in_data(in_data[0:0]), .out_valid(c_ov), .out_ready(out_ready), .out_data(c_od), .occ(c_occ));
    pipe_seg_hs #(.DW(1), .SKID(0), .RSTVAL(1'b0)) u_d (
        .clk(clk), .reset(rst), .flush(flush), .in_valid(in_valid), .in_ready(d_rdy),
        .in_data(in_data[0:0]), .out_valid(d_ov), .out_ready(out_ready), .out_data(d_od), .occ(d_occ));

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Compare one instance with the reference FIFO, then advance the reference
    // by the handshake that the coming edge will perform.
    task automatic sb(input int k, input logic rdy, input logic ov,
                      input logic [1:0] oc, input logic [159:0] od);
        logic exp_rdy;
        logic acc;
        logic pp;
        exp_rdy = skid[k] ? (cnt[k] != 2) : (cnt[k] == 0 || out_ready);
        check($sformatf("rnd%0d_rdy", k), rdy, exp_rdy);
        check($sformatf("rnd%0d_ov", k), ov, cnt[k] != 0);
        check($sformatf("rnd%0d_occ", k), oc, cnt[k]);
        if (cnt[k] > 0) check($sformatf("rnd%0d_data", k), od, e0[k]);
        acc = in_valid && exp_rdy;
        pp  = (cnt[k] > 0) && out_ready;
        if (flush) begin
            cnt[k] = 0;
        end else begin
            if (pp) begin
                e0[k]  = e1[k];
                cnt[k] = cnt[k] - 1;
            end
            if (acc) begin
                if (cnt[k] == 0) e0[k] = in_data & mask[k];
                else             e1[k] = in_data & mask[k];
                cnt[k] = cnt[k] + 1;
            end
        end
    endtask

    initial begin
        skid = '{1'b1, 1'b0, 1'b1, 1'b0};
        mask = '{{160{1'b1}}, {160{1'b1}}, 160'd1, 160'd1};
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        #3;
        // reset values
        check("rst_a_ov", a_ov, 0);
        check("rst_a_occ", a_occ, 0);
        check("rst_a_rdy", a_rdy, 1);
        check("rst_a_data", a_od, RV_A);
        check("rst_b_rdy", b_rdy, 1);
        check("rst_b_data", b_od, RV_A);
        check("rst_c_data", c_od, 1);
        cyc();
        rst = 1'b0;

        // stream with no backpressure: 1-cycle latency, in_ready stays high
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = 160'(i);
            cyc();
            check("strm_data", a_od, 160'(i));
            check("strm_ov", a_ov, 1);
            check("strm_occ", a_occ, 1);
            check("strm_rdy", a_rdy, 1);
        end
        in_valid = 1'b0;
        cyc();
        check("strm_drain_ov", a_ov, 0);

        // backpressure fills the skid buffer, then drains in order
        out_ready = 1'b0; in_valid = 1'b1; in_data = VAL_A;
        cyc();
        check("bp_occ1", a_occ, 1);
        in_data = VAL_B;
        cyc();
        check("bp_occ2", a_occ, 2);
        check("bp_rdy0", a_rdy, 0);
        check("bp_dataA", a_od, VAL_A);
        in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        check("bp_dataB", a_od, VAL_B);
        check("bp_occ_after_A", a_occ, 1);
        check("bp_rdy_after_A", a_rdy, 1);
        cyc();
        check("bp_empty_occ", a_occ, 0);
        check("bp_empty_ov", a_ov, 0);

        // flush with occ=2 and an incoming C
        out_ready = 1'b0; in_valid = 1'b1; in_data = VAL_A;
        cyc();
        in_data = VAL_B;
        cyc();
        in_data = VAL_C; flush = 1'b1;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        check("fl2_ov", a_ov, 0);
        check("fl2_occ", a_occ, 0);
        check("fl2_rdy", a_rdy, 1);
        check("fl2_stale", a_od, VAL_A);
        // flush in ONE where the accept of C would otherwise succeed
        in_valid = 1'b1; in_data = VAL_B;
        cyc();
        in_data = VAL_C; flush = 1'b1;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        check("fl1_ov", a_ov, 0);
        check("fl1_noC", a_od, VAL_B);
        cyc();
        check("fl1_still_empty", a_occ, 0);

        // SKID=0: same-cycle pop and accept
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1; in_data = VAL_A;
        #1;
        check("s0_rdy_empty", b_rdy, 1);
        cyc();
        check("s0_ov", b_ov, 1);
        check("s0_dataA", b_od, VAL_A);
        check("s0_rdy_full", b_rdy, 0);
        in_data = VAL_B; out_ready = 1'b1;
        #1;
        check("s0_rdy_pass", b_rdy, 1);
        cyc();
        check("s0_dataB", b_od, VAL_B);
        check("s0_ov_B", b_ov, 1);
        check("s0_occ_B", b_occ, 1);
        in_valid = 1'b0;
        cyc();
        check("s0_drain", b_ov, 0);

        // asynchronous reset mid-stream with occ=2
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1; in_data = VAL_A;
        cyc();
        in_data = VAL_B;
        cyc();
        check("mid_occ2", a_occ, 2);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_ov", a_ov, 0);
        check("mid_rst_occ", a_occ, 0);
        check("mid_rst_rdy", a_rdy, 1);
        check("mid_rst_data", a_od, RV_A);
        in_valid = 1'b0;
        cyc();
        rst = 1'b0;

        // random traffic against the reference FIFO
        for (int k = 0; k < 4; k++) begin
            cnt[k] = 0;
            e0[k]  = '0;
            e1[k]  = '0;
        end
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 60);
            flush     = ($urandom_range(0, 99) < 5);
            in_data   = {$urandom, $urandom, $urandom, $urandom, $urandom};
            #1;
            sb(0, a_rdy, a_ov, a_occ, a_od);
            sb(1, b_rdy, b_ov, b_occ, b_od);
            sb(2, c_rdy, c_ov, c_occ, {159'd0, c_od});
            sb(3, d_rdy, d_ov, d_occ, {159'd0, d_od});
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
